mem_stage_mc: RTL and testbench

Multi-cycle memory pipeline stage, parametrised successor of the single-cycle memory stage. Sits between execute and writeback.
- Accepts one op per valid/ready handshake.
- Issues aligned bus requests with byte strobes and waits an arbitrary number of cycles for a response.
- Extracts and sign/zero-extends load data; flags misaligned accesses.
- Presents the result to writeback through a registered valid/ready output.

---
 rtl/mem_stage_mc.sv | 161 ++++++++++++++++
 tb/tb_mem_stage_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: aligned bus request with byte strobes, variable-latency response, registered result.
// Optional flush input and DRAIN state are enabled with MEM_STAGE_FLUSH_EN.
module mem_stage_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 48
) (
  input  logic                clk,
  input  logic                resetn,
`ifdef MEM_STAGE_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_read,
  input  logic                in_write,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_strb,
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_exc,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

`ifdef MEM_STAGE_FLUSH_EN
  typedef enum logic [2:0] {s_idle, s_req, s_wait, s_done, s_drain} state_t;
`else
  typedef enum logic [1:0] {s_idle, s_req, s_wait, s_done} state_t;
`endif

  state_t state_reg, state_next, op_state;

  logic              accept, is_mem, misal;
  logic [OFFW-1:0]   in_off, low_mask, off_reg;
  logic [NB-1:0]     strb_next;
  logic [DATA_W-1:0] wdata_rep, addr_ext;
  logic [1:0]        size_reg;
  logic              sgn_reg, load_reg;
  logic [DATA_W-1:0] lane, ld_mask, ld_top, ld_ext;

  // Incoming op decode
  assign is_mem    = in_read | in_write;
  assign in_off    = in_addr[OFFW-1:0];
  assign low_mask  = OFFW'((4'd1 << in_size) - 4'd1);
  assign misal     = is_mem & (((in_off & low_mask) != '0) | ((in_size == 2'd3) && (DATA_W == 32)));
  assign strb_next = NB'(((16'd1 << (5'd1 << in_size)) - 16'd1) << in_off);
  assign addr_ext  = DATA_W'(in_addr);
  assign accept    = in_valid & in_ready;
  assign op_state  = (is_mem && !misal) ? s_req : s_done;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (in_size == 2'd0) ? in_wdata[7:0] :
                                  (in_size == 2'd1) ? in_wdata[8*(gi%2) +: 8] :
                                  (in_size == 2'd2) ? in_wdata[8*(gi%4) +: 8] :
                                                      in_wdata[8*(gi%8) +: 8];
  end

  // Load extraction from the registered offset/size of the op in flight
  assign lane = resp_data >> {off_reg, 3'b000};

  always_comb begin
    case (size_reg)
      2'd0:    ld_mask = DATA_W'(8'hFF);
      2'd1:    ld_mask = DATA_W'(16'hFFFF);
      2'd2:    ld_mask = DATA_W'(32'hFFFF_FFFF);
      default: ld_mask = '1;
    endcase
  end

  assign ld_top = ld_mask & ~(ld_mask >> 1);
  assign ld_ext = (lane & ld_mask) | ((sgn_reg && ((lane & ld_top) != '0)) ? ~ld_mask : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= s_idle;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      s_idle: if (accept) state_next = op_state;
      s_req: begin
        if (req_ready) state_next = s_wait;
`ifdef MEM_STAGE_FLUSH_EN
        if (flush) state_next = req_ready ? s_drain : s_idle;
`endif
      end
      s_wait: begin
        if (resp_valid) state_next = s_done;
`ifdef MEM_STAGE_FLUSH_EN
        if (flush) state_next = resp_valid ? s_idle : s_drain;
`endif
      end
      s_done: begin
        if (out_ready) state_next = accept ? op_state : s_idle;
`ifdef MEM_STAGE_FLUSH_EN
        if (flush) state_next = s_idle;
`endif
      end
`ifdef MEM_STAGE_FLUSH_EN
      s_drain: if (resp_valid) state_next = s_idle;
`endif
      default: state_next = s_idle;
    endcase
  end

  always_comb begin
    req_valid = (state_reg == s_req);
    out_valid = (state_reg == s_done);
    in_ready  = (state_reg == s_idle) | ((state_reg == s_done) & out_ready);
`ifdef MEM_STAGE_FLUSH_EN
    in_ready  = in_ready & ~flush;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
      off_reg   <= '0;
      size_reg  <= 2'd0;
      sgn_reg   <= 1'b0;
      load_reg  <= 1'b0;
      out_data  <= '0;
      out_exc   <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      req_write <= in_write;
      req_addr  <= {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
      req_wdata <= wdata_rep;
      req_strb  <= strb_next;
      off_reg   <= in_off;
      size_reg  <= in_size;
      sgn_reg   <= in_signed;
      load_reg  <= in_read & ~in_write;
      out_data  <= addr_ext;
      out_exc   <= misal;
      out_tag   <= in_tag;
    end else if ((state_reg == s_wait) && resp_valid && load_reg) begin
      out_data  <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: 32-bit and 64-bit instances, vector table plus multi-cycle sequences.
module tb_mem_stage_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int checks = 0;
  int failures = 0;

  logic        a_in_valid, a_in_ready, a_in_read, a_in_write, a_in_signed;
  logic [1:0]  a_in_size;
  logic [31:0] a_in_addr, a_in_wdata;
  logic [47:0] a_in_tag;
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_strb;
  logic        a_resp_valid;
  logic [31:0] a_resp_data;
  logic        a_out_valid, a_out_ready, a_out_exc;
  logic [31:0] a_out_data;
  logic [47:0] a_out_tag;

  logic        b_in_valid, b_in_ready, b_in_read, b_in_write, b_in_signed;
  logic [1:0]  b_in_size;
  logic [31:0] b_in_addr;
  logic [63:0] b_in_wdata;
  logic [47:0] b_in_tag;
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_strb;
  logic        b_resp_valid;
  logic [63:0] b_resp_data;
  logic        b_out_valid, b_out_ready, b_out_exc;
  logic [63:0] b_out_data;
  logic [47:0] b_out_tag;

`ifdef MEM_STAGE_FLUSH_EN
  logic a_flush, b_flush;
`endif

  mem_stage_mc #(.DATA_W(32), .ADDR_W(32), .TAG_W(48)) u_dut32 (
    .clk(clk), .resetn(resetn),
`ifdef MEM_STAGE_FLUSH_EN
    .flush(a_flush),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_read(a_in_read), .in_write(a_in_write),
    .in_size(a_in_size), .in_signed(a_in_signed), .in_addr(a_in_addr), .in_wdata(a_in_wdata),
    .in_tag(a_in_tag), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_strb(a_req_strb),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_exc(a_out_exc), .out_tag(a_out_tag)
  );

  mem_stage_mc #(.DATA_W(64), .ADDR_W(32), .TAG_W(48)) u_dut64 (
    .clk(clk), .resetn(resetn),
`ifdef MEM_STAGE_FLUSH_EN
    .flush(b_flush),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_read(b_in_read), .in_write(b_in_write),
    .in_size(b_in_size), .in_signed(b_in_signed), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
    .in_tag(b_in_tag), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_exc(b_out_exc), .out_tag(b_out_tag)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic        req;
    logic [3:0]  strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int i);
    logic [47:0] tag;
    tag = {16'hC0DE, 32'(i)};
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", i), a_in_ready, 1);
    a_in_valid = 1'b1; a_in_read = v.rd; a_in_write = v.wr; a_in_size = v.size;
    a_in_signed = v.sgn; a_in_addr = v.addr; a_in_wdata = v.wdata; a_in_tag = tag;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    if (v.req) begin
      chk($sformatf("v%0d_req_valid", i), a_req_valid, 1);
      chk($sformatf("v%0d_req_write", i), a_req_write, v.wr);
      chk($sformatf("v%0d_req_addr", i), a_req_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_req_strb", i), a_req_strb, v.strb);
      if (v.wr) chk($sformatf("v%0d_req_wdata", i), a_req_wdata, v.exp_wdata);
      chk($sformatf("v%0d_busy_in_ready", i), a_in_ready, 0);
      a_req_ready = 1'b1;
      @(negedge clk);
      a_req_ready = 1'b0;
      chk($sformatf("v%0d_wait_req_valid", i), a_req_valid, 0);
      a_resp_valid = 1'b1; a_resp_data = v.resp;
      @(negedge clk);
      a_resp_valid = 1'b0;
    end else begin
      chk($sformatf("v%0d_no_req", i), a_req_valid, 0);
    end
    chk($sformatf("v%0d_out_valid", i), a_out_valid, 1);
    chk($sformatf("v%0d_out_data", i), a_out_data, v.exp_data);
    chk($sformatf("v%0d_out_exc", i), a_out_exc, v.exc);
    chk($sformatf("v%0d_out_tag", i), a_out_tag, tag);
    $display("txn %0d rd=%0b wr=%0b size=%0d addr=0x%08h -> data=0x%08h exc=%0b",
             i, v.rd, v.wr, v.size, v.addr, a_out_data, a_out_exc);
    @(negedge clk);
    chk($sformatf("v%0d_out_drop", i), a_out_valid, 0);
  endtask

  task automatic run64(input string name, input logic [1:0] size, input logic [31:0] addr,
                       input logic [63:0] resp, input logic [7:0] exp_strb, input logic [63:0] exp_data);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_read = 1'b1; b_in_write = 1'b0; b_in_size = size;
    b_in_signed = 1'b0; b_in_addr = addr; b_in_tag = 48'h64; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk({name, "_req_valid"}, b_req_valid, 1);
    chk({name, "_req_addr"}, b_req_addr, 32'h8);
    chk({name, "_req_strb"}, b_req_strb, exp_strb);
    b_req_ready = 1'b1;
    @(negedge clk);
    b_req_ready = 1'b0; b_resp_valid = 1'b1; b_resp_data = resp;
    @(negedge clk);
    b_resp_valid = 1'b0;
    chk({name, "_out_valid"}, b_out_valid, 1);
    chk({name, "_out_data"}, b_out_data, exp_data);
    $display("txn %s addr=0x%08h -> data=0x%016h", name, addr, b_out_data);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h8000_0000, 1'b1, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h2002, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h3001, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'hFFFF, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h4002, 32'h0, 32'h8765_4321, 1'b1, 4'b1100, 32'h0, 32'h0000_8765, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h8765_4321, 1'b1, 4'b1100, 32'h0, 32'hFFFF_8765, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h4001, 32'h0, 32'h8765_4321, 1'b1, 4'b0010, 32'h0, 32'h0000_0043, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h5000, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h6001, 32'h1234_56A5, 32'h0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h6001, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h7000, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h7000, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h8000, 32'hCAFE_F00D, 32'h55, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h8000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h9002, 32'h1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h9002, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'hA001, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hA001, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h4000, 32'h0, 32'h0000_007F, 1'b1, 4'b0001, 32'h0, 32'h0000_007F, 1'b0};

    resetn = 1'b0;
    a_in_valid = 0; a_in_read = 0; a_in_write = 0; a_in_size = 0; a_in_signed = 0;
    a_in_addr = 0; a_in_wdata = 0; a_in_tag = 0; a_req_ready = 0; a_resp_valid = 0;
    a_resp_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_read = 0; b_in_write = 0; b_in_size = 0; b_in_signed = 0;
    b_in_addr = 0; b_in_wdata = 0; b_in_tag = 0; b_req_ready = 0; b_resp_valid = 0;
    b_resp_data = 0; b_out_ready = 0;
`ifdef MEM_STAGE_FLUSH_EN
    a_flush = 0; b_flush = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_req_valid", a_req_valid, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_exc", a_out_exc, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_req_addr", a_req_addr, 0);
    chk("rst_in_ready", a_in_ready, 1);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vecs[i], i);

    // Bus stall, response in the REQ cycle ignored, writeback stall
    @(negedge clk);
    a_in_valid = 1; a_in_read = 1; a_in_write = 0; a_in_size = 2'd2; a_in_signed = 0;
    a_in_addr = 32'h5004; a_in_tag = 48'hABC; a_out_ready = 0;
    @(negedge clk);
    a_in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req_valid", k), a_req_valid, 1);
      chk($sformatf("stall%0d_req_addr", k), a_req_addr, 32'h5004);
      chk($sformatf("stall%0d_req_strb", k), a_req_strb, 4'hF);
      chk($sformatf("stall%0d_in_ready", k), a_in_ready, 0);
      @(negedge clk);
    end
    a_req_ready = 1; a_resp_valid = 1; a_resp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    a_req_ready = 0; a_resp_valid = 0;
    chk("early_resp_ignored", a_out_valid, 0);
    @(negedge clk);
    chk("wait_hold", a_out_valid, 0);
    a_resp_valid = 1; a_resp_data = 32'h1122_3344;
    @(negedge clk);
    a_resp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_out_valid", k), a_out_valid, 1);
      chk($sformatf("hold%0d_out_data", k), a_out_data, 32'h1122_3344);
      chk($sformatf("hold%0d_in_ready", k), a_in_ready, 0);
      @(negedge clk);
    end
    $display("txn stall lw addr=0x00005004 -> data=0x%08h", a_out_data);
    a_out_ready = 1;
    @(negedge clk);
    chk("hold_release", a_out_valid, 0);

    // Back-to-back non-memory ops
    a_in_valid = 1; a_in_read = 0; a_in_write = 0; a_in_addr = 32'h111;
    @(negedge clk);
    chk("b2b_first_valid", a_out_valid, 1);
    chk("b2b_first_data", a_out_data, 32'h111);
    chk("b2b_in_ready", a_in_ready, 1);
    a_in_addr = 32'h222;
    @(negedge clk);
    a_in_valid = 0;
    chk("b2b_second_valid", a_out_valid, 1);
    chk("b2b_second_data", a_out_data, 32'h222);
    $display("txn b2b nonmem -> data=0x%08h", a_out_data);
    @(negedge clk);
    chk("b2b_drain", a_out_valid, 0);

    // Asynchronous reset in WAIT
    a_in_valid = 1; a_in_read = 1; a_in_size = 2'd2; a_in_addr = 32'h6000; a_in_tag = 48'h77;
    @(negedge clk);
    a_in_valid = 0; a_req_ready = 1;
    @(negedge clk);
    a_req_ready = 0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_req_valid", a_req_valid, 0);
    chk("arst_out_data", a_out_data, 0);
    chk("arst_out_tag", a_out_tag, 0);
    chk("arst_req_addr", a_req_addr, 0);
    @(negedge clk);
    resetn = 1'b1; a_resp_valid = 1; a_resp_data = 32'h5;
    @(negedge clk);
    a_resp_valid = 0;
    chk("arst_no_out", a_out_valid, 0);
    chk("arst_no_req", a_req_valid, 0);
    $display("txn reset mid-op -> out_valid=%0b", a_out_valid);

    run64("ld64", 2'd3, 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
    run64("lhu64", 2'd1, 32'hE, 64'h0123_4567_89AB_CDEF, 8'hC0, 64'h0000_0000_0000_0123);

`ifdef MEM_STAGE_FLUSH_EN
    // Flush in WAIT drains the late response without producing a result
    @(negedge clk);
    a_in_valid = 1; a_in_read = 1; a_in_write = 0; a_in_size = 2'd2; a_in_addr = 32'h5000;
    @(negedge clk);
    a_in_valid = 0; a_req_ready = 1;
    @(negedge clk);
    a_req_ready = 0; a_flush = 1;
    @(negedge clk);
    a_flush = 0;
    chk("drain_in_ready0", a_in_ready, 0);
    chk("drain_out_valid0", a_out_valid, 0);
    @(negedge clk);
    chk("drain_in_ready1", a_in_ready, 0);
    a_resp_valid = 1; a_resp_data = 32'h1234;
    @(negedge clk);
    a_resp_valid = 0;
    chk("drain_done_in_ready", a_in_ready, 1);
    chk("drain_done_out_valid", a_out_valid, 0);
    @(negedge clk);
    chk("drain_idle_out_valid", a_out_valid, 0);
    $display("txn flush-in-wait -> out_valid=%0b in_ready=%0b", a_out_valid, a_in_ready);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
